// File: rtl/mm_bst_ram_slave.sv
// Burst-capable memory-mapped slave on on-chip RAM: zero-wait write bursts, reads with latency 2.
// Optional busy-stall injection is enabled by defining MM_BST_RAM_SLAVE_STALL_EN.
module mm_bst_ram_slave #(
   parameter int DWIDTH  = 16,
   parameter int AWIDTH  = 8,
   parameter int BWIDTH  = 4,
   parameter     RAMTYPE = "AUTO"
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] s_addr,
   input  logic [BWIDTH-1:0] s_bcnt,
   input  logic              s_wreq,
   input  logic [DWIDTH-1:0] s_wdat,
   input  logic              s_rreq,
   output logic [DWIDTH-1:0] s_rdat,
   output logic              s_rval,
   output logic              s_busy,
   output logic [1:0]        dbg_state_o
);

   // Handshake: a request (s_wreq or s_rreq) is consumed on a rising clk edge only when
   // s_busy is 0 in that cycle; s_rdat is meaningful only in cycles where s_rval is 1.
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   ptr_q, ptr_d;
   logic [BWIDTH:0]     rem_q, rem_d;
   logic [BWIDTH:0]     cmd_len;
   logic [BWIDTH:0]     len_one;
   logic [AWIDTH-1:0]   waddr;
   logic                we, re;
   logic                busy;
   logic [DWIDTH-1:0]   rdat_q;
   logic                rval_q;

   (* ram_style = RAMTYPE *) logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

   // A zero burst count stands for the full 2**BWIDTH words, hence the extra counter bit.
   assign cmd_len = (s_bcnt == '0) ? {1'b1, {BWIDTH{1'b0}}} : {1'b0, s_bcnt};
   assign len_one = {{BWIDTH{1'b0}}, 1'b1};

`ifdef MM_BST_RAM_SLAVE_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign busy = (state_q == READ) | (lfsr_q[0] & ~reset);
`else
   assign busy = (state_q == READ);
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      waddr   = ptr_q;
      we      = 1'b0;
      re      = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_wreq && !busy) begin
               we    = 1'b1;
               waddr = s_addr;
               ptr_d = s_addr + 1'b1;
               rem_d = cmd_len - 1'b1;
               if (cmd_len != len_one) state_d = WRITE;
            end else if (s_rreq && !busy) begin
               ptr_d   = s_addr;
               rem_d   = cmd_len;
               state_d = READ;
            end
         end
         WRITE: begin
            if (s_wreq && !busy) begin
               we    = 1'b1;
               ptr_d = ptr_q + 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == len_one) state_d = IDLE;
            end
         end
         READ: begin
            // One extra cycle after the last issue keeps busy high while the last beat is shown.
            if (rem_q != '0) begin
               re    = 1'b1;
               ptr_d = ptr_q + 1'b1;
               rem_d = rem_q - 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         rval_q  <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         rval_q  <= re;
         if (re) rdat_q <= mem[ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= s_wdat;
   end

   assign s_rdat      = rdat_q;
   assign s_rval      = rval_q;
   assign s_busy      = busy;
   assign dbg_state_o = state_q;

endmodule
